dft_bin_accumulator: RTL

- Sits directly downstream of the 8-input CORDIC rotation pipeline.
- Consumes the stream of twiddle-rotated complex samples, one per cycle. Every N_POINTS consecutive samples are summed into one DFT bin X[k].
- Each bin is scaled, rounded and saturated, then queued in a 2-entry output FIFO with a valid/ready handshake toward the downstream consumer (magnitude or storage stage).

---
 rtl/dft_pkg.sv | 45 ++++
 rtl/dft_out_fifo.sv | 66 ++++++
 rtl/dft_bin_accumulator.sv | 106 ++++++++++
 3 files changed

// File: rtl/dft_pkg.sv
// Shared types and scaling helper for the DFT bin stages.
// DFT_ACC_SAT_EN selects saturation instead of wrap when narrowing a scaled sum to OUT_W.
package dft_pkg;

  localparam int N_POINTS            = 8;
  localparam int DATA_W              = 16;
  localparam int ACC_W               = DATA_W + $clog2(N_POINTS);
  localparam int OUT_W               = 16;
  localparam int BIN_W               = $clog2(N_POINTS);
  localparam int DEFAULT_SCALE_SHIFT = 3;

`ifdef DFT_ACC_SAT_EN
  localparam logic signed [ACC_W:0] SAT_MAX = (ACC_W+1)'(2**(OUT_W-1) - 1);
  localparam logic signed [ACC_W:0] SAT_MIN = -(ACC_W+1)'(2**(OUT_W-1));
`endif

  typedef struct packed {
    logic signed [OUT_W-1:0] re;
    logic signed [OUT_W-1:0] im;
    logic [BIN_W-1:0]        bin;
    logic                    last;
  } bin_result_t;

  // Round half up, arithmetic shift, then narrow to OUT_W; one extra bit keeps the rounding add safe.
  function automatic logic signed [OUT_W-1:0] scale_bin(input logic signed [ACC_W-1:0] sum,
                                                        input int shift);
    logic signed [ACC_W:0] rounded;
    logic signed [ACC_W:0] shifted;
    rounded = {sum[ACC_W-1], sum};
    if (shift > 0)
      rounded = rounded + $signed((ACC_W+1)'(1) << (shift - 1));
    shifted = rounded >>> shift;
`ifdef DFT_ACC_SAT_EN
    if (shifted > SAT_MAX)
      return OUT_W'(SAT_MAX);
    else if (shifted < SAT_MIN)
      return OUT_W'(SAT_MIN);
    else
      return OUT_W'(shifted);
`else
    return OUT_W'(shifted);
`endif
  endfunction

endpackage

// File: rtl/dft_out_fifo.sv
// Two-entry valid/ready FIFO of finished DFT bins; the head entry drives the outputs directly.
module dft_out_fifo
  import dft_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        push,
  input  bin_result_t push_data,
  input  logic        ready,
  output logic        valid,
  output bin_result_t head,
  output logic        full
);

  logic [1:0]  count;
  bin_result_t tail;
  logic        pop;

  assign valid = (count != 2'd0);
  assign full  = (count == 2'd2);
  assign pop   = valid && ready;

  // A push into a full FIFO without a pop is ignored here; the parent flags the drop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= 2'd0;
      head  <= '0;
      tail  <= '0;
    end else if (flush) begin
      count <= 2'd0;
      head  <= '0;
      tail  <= '0;
    end else begin
      case (count)
        2'd0: begin
          if (push) begin
            head  <= push_data;
            count <= 2'd1;
          end
        end
        2'd1: begin
          if (push && pop) begin
            head <= push_data;
          end else if (push) begin
            tail  <= push_data;
            count <= 2'd2;
          end else if (pop) begin
            count <= 2'd0;
          end
        end
        2'd2: begin
          if (pop) begin
            head <= tail;
            if (push)
              tail <= push_data;
            else
              count <= 2'd1;
          end
        end
        default: count <= 2'd0;
      endcase
    end
  end

endmodule

// File: rtl/dft_bin_accumulator.sv
// Sums every N_POINTS rotated CORDIC samples into one DFT bin, scales it and queues it for the consumer.
// Build with DFT_ACC_SAT_EN defined to saturate the scaled bin instead of wrapping it.
module dft_bin_accumulator
  import dft_pkg::*;
#(
  parameter int SCALE_SHIFT = DEFAULT_SCALE_SHIFT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    in_valid,
  input  logic signed [DATA_W-1:0] in_x,
  input  logic signed [DATA_W-1:0] in_y,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] out_re,
  output logic signed [OUT_W-1:0] out_im,
  output logic [BIN_W-1:0]        out_bin,
  output logic                    out_last,
  output logic                    overflow
);

  logic [BIN_W-1:0]        sample_cnt;
  logic [BIN_W-1:0]        bin_cnt;
  logic signed [ACC_W-1:0] acc_re;
  logic signed [ACC_W-1:0] acc_im;
  logic signed [ACC_W-1:0] x_ext;
  logic signed [ACC_W-1:0] y_ext;
  logic signed [ACC_W-1:0] base_re;
  logic signed [ACC_W-1:0] base_im;
  logic signed [ACC_W-1:0] sum_re;
  logic signed [ACC_W-1:0] sum_im;
  logic                    take;
  logic                    bin_done;
  logic                    fifo_full;
  logic                    drop;
  bin_result_t             result;
  bin_result_t             head;

  assign take     = in_valid && !flush;
  assign bin_done = take && (sample_cnt == BIN_W'(N_POINTS - 1));

  assign x_ext = {{(ACC_W-DATA_W){in_x[DATA_W-1]}}, in_x};
  assign y_ext = {{(ACC_W-DATA_W){in_y[DATA_W-1]}}, in_y};

  // The first sample of a bin loads the accumulator rather than adding to the previous bin's total.
  assign base_re = (sample_cnt == '0) ? '0 : acc_re;
  assign base_im = (sample_cnt == '0) ? '0 : acc_im;
  assign sum_re  = base_re + x_ext;
  assign sum_im  = base_im + y_ext;

  assign result.re   = scale_bin(sum_re, SCALE_SHIFT);
  assign result.im   = scale_bin(sum_im, SCALE_SHIFT);
  assign result.bin  = bin_cnt;
  assign result.last = (bin_cnt == BIN_W'(N_POINTS - 1));

  assign drop = bin_done && fifo_full && !(out_valid && out_ready);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sample_cnt <= '0;
      bin_cnt    <= '0;
      acc_re     <= '0;
      acc_im     <= '0;
    end else if (flush) begin
      sample_cnt <= '0;
      bin_cnt    <= '0;
      acc_re     <= '0;
      acc_im     <= '0;
    end else if (take) begin
      acc_re     <= sum_re;
      acc_im     <= sum_im;
      sample_cnt <= sample_cnt + BIN_W'(1);
      // Bin index advances even on a dropped bin so indices stay aligned to the frame.
      if (bin_done)
        bin_cnt <= bin_cnt + BIN_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      overflow <= 1'b0;
    else if (flush)
      overflow <= 1'b0;
    else if (drop)
      overflow <= 1'b1;
  end

  dft_out_fifo u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .push      (bin_done),
    .push_data (result),
    .ready     (out_ready),
    .valid     (out_valid),
    .head      (head),
    .full      (fifo_full)
  );

  assign out_re   = head.re;
  assign out_im   = head.im;
  assign out_bin  = head.bin;
  assign out_last = head.last;

endmodule
